// File: rtl/checkpoint_scheduler.sv
// checkpoint_scheduler: round-robin arbiter sharing one checkpoint datapath among NUM_REQ requesters
//   clk, reset_n (async active-low)
//   req_valid/req_task_id : one-cycle request pulses with per-requester task IDs
//   req_done/req_timeout  : one-hot completion pulse back to the granted requester, abort status
//   req_overflow          : sticky per-requester dropped-request flags
//   comparator_checkpoint/comparator_task_id/checkpoint_ack : checkpoint block handshake
//   busy, err_timeout     : FSM not idle, sticky timeout seen
//   Optional macro CHECKPOINT_SCHED_TIMEOUT_EN adds the WAIT timeout counter.
`ifndef CRC_KEY_WIDTH
`define CRC_KEY_WIDTH 8
`endif
module checkpoint_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int KEY_W = `CRC_KEY_WIDTH,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*KEY_W-1:0] req_task_id,
  output logic [NUM_REQ-1:0]       req_done,
  output logic                     req_timeout,
  output logic [NUM_REQ-1:0]       req_overflow,
  output logic                     comparator_checkpoint,
  output logic [KEY_W-1:0]         comparator_task_id,
  input  logic                     checkpoint_ack,
  output logic                     busy,
  output logic                     err_timeout
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [NUM_REQ-1:0] pending, clr;
  logic [KEY_W-1:0] ids [NUM_REQ];
  logic [IW-1:0] last_grant, grant, sel, j;
  logic found, expire;
  // first pending requester after last_grant, wrapping modulo NUM_REQ
  always_comb begin
    found = 1'b0;
    sel = last_grant;
    j = last_grant;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = IW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && pending[j]) begin
        found = 1'b1;
        sel = j;
      end
    end
  end
  always_comb clr = (state == DONE) ? NUM_REQ'(1) << grant : '0;
  // a request arriving while its own slot is being cleared is kept (set wins)
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pending <= '0;
      req_overflow <= '0;
      for (int i = 0; i < NUM_REQ; i++) ids[i] <= '0;
    end else
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && (!pending[i] || clr[i])) begin
          pending[i] <= 1'b1;
          ids[i] <= req_task_id[i*KEY_W +: KEY_W];
        end else if (clr[i]) pending[i] <= 1'b0;
        if (req_valid[i] && pending[i] && !clr[i]) req_overflow[i] <= 1'b1;
      end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      comparator_task_id <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) begin
        grant <= sel;
        last_grant <= sel;
        comparator_task_id <= ids[sel];
      end
    end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = found ? ISSUE : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = (checkpoint_ack || expire) ? DONE : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  assign comparator_checkpoint = state == ISSUE;
  assign busy = state != IDLE;
  assign req_done = clr;
`ifdef CHECKPOINT_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic status;
  assign expire = state == WAIT && cnt == CW'(TIMEOUT - 1);
  // an ack on the expiring cycle wins, so status only records a true abort
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      status <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      cnt <= (state == WAIT) ? cnt + CW'(1) : '0;
      if (state == WAIT) status <= !checkpoint_ack && expire;
      if (state == WAIT && !checkpoint_ack && expire) err_timeout <= 1'b1;
    end
  assign req_timeout = state == DONE && status;
`else
  assign expire = 1'b0;
  assign req_timeout = 1'b0;
  assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_checkpoint_scheduler.sv
// tb_checkpoint_scheduler: scoreboard bench with a transaction-level timing model of the scheduler
module tb_checkpoint_scheduler;
  localparam int N = 4, KW = 8, TO = 8;
`ifdef CHECKPOINT_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, reset_n;
  logic [N-1:0] req_valid, req_done, req_overflow;
  logic [N*KW-1:0] req_task_id;
  logic req_timeout, comparator_checkpoint, checkpoint_ack, busy, err_timeout;
  logic [KW-1:0] comparator_task_id;
  int checks = 0, errors = 0;
  checkpoint_scheduler #(.NUM_REQ(N), .KEY_W(KW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_task_id(req_task_id),
    .req_done(req_done), .req_timeout(req_timeout), .req_overflow(req_overflow),
    .comparator_checkpoint(comparator_checkpoint), .comparator_task_id(comparator_task_id),
    .checkpoint_ack(checkpoint_ack), .busy(busy), .err_timeout(err_timeout)
  );
  always #5 clk = ~clk;
  typedef struct {bit done; int cyc; int idx; logic [KW-1:0] id; bit to;} item_t;
  item_t exp_q[$];
  logic [KW-1:0] issued[$];
  logic [N-1:0] last_done;
  logic last_to;
  int cyc = 0, cc_cnt = 0;
  bit mp[N];
  logic [KW-1:0] mid[N];
  int mlast, mG, mD, mg;
  bit mact, merr;
  logic [N-1:0] mov;
  logic [KW-1:0] mgid;
  function automatic item_t mk(bit done, int c, int idx, logic [KW-1:0] id, bit to);
    item_t it;
    it.done = done; it.cyc = c; it.idx = idx; it.id = id; it.to = to;
    return it;
  endfunction
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Job timeline: grant at edge G, pulse in cycle G, first ack-sampling edge G+2,
  // timeout edge G+1+TO, done cycle D, idle again from edge D+1, next grant no earlier than D+2.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin mp[i] = 0; mid[i] = '0; end
      mlast = N - 1; mact = 0; mD = -1; mG = 0; mg = 0; mgid = '0; merr = 0; mov = '0;
      exp_q.delete();
    end else begin
      int clr;
      cyc++;
      if (mact && mD < 0 && cyc >= mG + 2) begin
        if (checkpoint_ack) mD = cyc;
        else if (TO_EN && cyc == mG + 1 + TO) begin mD = cyc; merr = 1; end
        if (mD == cyc) exp_q.push_back(mk(1, cyc, mg, mgid, !checkpoint_ack));
      end
      clr = (mact && mD >= 0 && cyc == mD + 1) ? mg : -1;
      if (!mact || (mD >= 0 && cyc >= mD + 2)) begin
        mact = 0;
        for (int k = 1; k <= N && !mact; k++)
          if (mp[(mlast + k) % N]) begin
            mact = 1; mg = (mlast + k) % N; mG = cyc; mD = -1; mlast = mg; mgid = mid[mg];
            exp_q.push_back(mk(0, cyc, mg, mgid, 0));
          end
      end
      for (int i = 0; i < N; i++)
        if (req_valid[i] && (!mp[i] || clr == i)) begin mp[i] = 1; mid[i] = req_task_id[i*KW +: KW]; end
        else if (req_valid[i]) mov[i] = 1;
        else if (clr == i) mp[i] = 0;
    end
  end
  always @(negedge clk) if (reset_n) begin
    item_t it;
    if (comparator_checkpoint) cc_cnt++;
    if (req_done != 0) begin last_done = req_done; last_to = req_timeout; end
    if (comparator_checkpoint || req_done != 0 || (exp_q.size() > 0 && exp_q[0].cyc <= cyc)) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: cc=%0b done=%b with nothing expected (cycle %0d)", comparator_checkpoint, req_done, cyc);
      end else begin
        it = exp_q.pop_front();
        chk("event_cycle", cyc, it.cyc);
        if (it.done) begin
          chk("req_done", req_done, 1 << it.idx);
          chk("req_timeout", req_timeout, it.to);
          chk("done_task_id", comparator_task_id, it.id);
          chk("done_no_pulse", comparator_checkpoint, 0);
        end else begin
          chk("issue_pulse", comparator_checkpoint, 1);
          chk("issue_task_id", comparator_task_id, it.id);
          chk("issue_no_done", req_done, 0);
          if (comparator_checkpoint) issued.push_back(comparator_task_id);
        end
      end
    end
    chk("busy", busy, mact && (mD < 0 || cyc <= mD));
    chk("overflow", req_overflow, mov);
    chk("err_timeout", err_timeout, merr);
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic run(input int n);
    repeat (n) tick();
  endtask
  task automatic set_req(input int i, input logic [KW-1:0] id);
    req_valid[i] = 1'b1;
    req_task_id[i*KW +: KW] = id;
  endtask
  task automatic pulse();
    tick();
    req_valid = '0;
  endtask
  task automatic do_reset();
    req_valid = '0; checkpoint_ack = 1'b0; reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    issued.delete();
    last_done = '0; last_to = 1'b0;
  endtask
  task automatic wait_grant(input int g, input int extra);
    int n = 0;
    while (!(mact && mD < 0 && mg == g && cyc >= mG + 1 + extra) && n < 100) begin tick(); n++; end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL wait_grant: requester %0d never reached WAIT+%0d", g, extra); end
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_cc"}, comparator_checkpoint, 0);
    chk({tag, "_done"}, req_done, 0);
    chk({tag, "_to"}, req_timeout, 0);
    chk({tag, "_ovf"}, req_overflow, 0);
    chk({tag, "_id"}, comparator_task_id, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err_timeout, 0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int c0;
    reset_n = 1'b0; req_valid = '0; req_task_id = '0; checkpoint_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    reset_n = 1'b1;
    tick();
    do_reset();
    set_req(2, 8'h05); pulse();
    run(3);
    checkpoint_ack = 1'b1; tick(); checkpoint_ack = 1'b0;
    run(5);
    chk("single_issue_count", issued.size(), 1);
    if (issued.size() > 0) chk("single_issue_id", issued[0], 8'h05);
    chk("single_done", last_done, 4'b0100);
    chk("single_timeout", last_to, 0);
    do_reset();
    checkpoint_ack = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 8'h10 + 8'(i));
    pulse(); run(25);
    set_req(3, 8'h23); set_req(0, 8'h20); pulse(); run(12);
    checkpoint_ack = 1'b0;
    chk("rr_count", issued.size(), 6);
    if (issued.size() == 6) begin
      chk("rr_0", issued[0], 8'h10); chk("rr_1", issued[1], 8'h11);
      chk("rr_2", issued[2], 8'h12); chk("rr_3", issued[3], 8'h13);
      chk("rr_wrap_0", issued[4], 8'h20); chk("rr_wrap_3", issued[5], 8'h23);
    end
    do_reset();
    set_req(0, 8'h30); pulse(); run(2);
    set_req(1, 8'h31); pulse();
    set_req(1, 8'h32); pulse();
    chk("ovf_bits", req_overflow, 4'b0010);
    checkpoint_ack = 1'b1; tick(); checkpoint_ack = 1'b0;
    wait_grant(1, 0);
    checkpoint_ack = 1'b1; tick();
    checkpoint_ack = 1'b0; set_req(1, 8'h33); pulse();
    checkpoint_ack = 1'b1; run(12); checkpoint_ack = 1'b0;
    chk("ovf_issue_count", issued.size(), 3);
    if (issued.size() == 3) begin
      chk("ovf_issue_0", issued[0], 8'h30);
      chk("ovf_issue_1", issued[1], 8'h31);
      chk("ovf_reissue", issued[2], 8'h33);
    end
`ifdef CHECKPOINT_SCHED_TIMEOUT_EN
    do_reset();
    set_req(2, 8'h40); pulse(); run(TO + 6);
    chk("to_done", last_done, 4'b0100);
    chk("to_status", last_to, 1);
    chk("to_err_sticky", err_timeout, 1);
    set_req(3, 8'h41); pulse();
    wait_grant(3, TO - 1);
    checkpoint_ack = 1'b1; tick(); checkpoint_ack = 1'b0;
    run(4);
    chk("to_edge_done", last_done, 4'b1000);
    chk("to_edge_status", last_to, 0);
    chk("to_edge_err_sticky", err_timeout, 1);
`else
    do_reset();
    c0 = cc_cnt;
    set_req(0, 8'h70); pulse(); run(1000);
    chk("noto_busy", busy, 1);
    chk("noto_err", err_timeout, 0);
    chk("noto_one_pulse", cc_cnt - c0, 1);
`endif
    do_reset();
    set_req(0, 8'h50); pulse(); run(3);
    set_req(1, 8'h51); set_req(2, 8'h52); pulse();
    #3 reset_n = 1'b0;
    #1 check_zero("midreset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    c0 = cc_cnt;
    run(10);
    chk("midreset_no_issue", cc_cnt - c0, 0);
    set_req(1, 8'h60); pulse();
    checkpoint_ack = 1'b1; run(6); checkpoint_ack = 1'b0;
    chk("midreset_new_issue", cc_cnt - c0, 1);
    do_reset();
    repeat (1500) begin
      for (int i = 0; i < N; i++) req_valid[i] = ($urandom_range(0, 5) == 0);
      req_task_id = $urandom;
      checkpoint_ack = ($urandom_range(0, 2) == 0);
      tick();
    end
    req_valid = '0; checkpoint_ack = 1'b1;
    run(40);
    checkpoint_ack = 1'b0;
    run(2);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/checkpoint_scheduler.md
# checkpoint_scheduler

Round-robin scheduler that shares the single checkpoint datapath between several comparator requesters. Each requester posts a one-cycle checkpoint request carrying its task ID. The scheduler latches it, grants requests one at a time, drives the checkpoint block's `comparator_checkpoint`/`comparator_task_id` inputs, and waits for `checkpoint_ack`. Completion, optionally with a timeout status, is reported back to the originating requester.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; valid range 2..8.
- `KEY_W`, `` `CRC_KEY_WIDTH ``: task ID width.
- `TIMEOUT`, 255: maximum WAIT cycles before abort; only used when the timeout feature is compiled in.

Ports:
- `clk`, in, 1: single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, NUM_REQ: one-cycle request pulse per requester.
- `req_task_id`, in, NUM_REQ*KEY_W: task IDs; requester i uses slice [i*KEY_W +: KEY_W], sampled together with `req_valid[i]`.
- `req_done`, out, NUM_REQ: one-hot, one-cycle completion pulse.
- `req_timeout`, out, 1: high with `req_done` when the completion was an abort.
- `req_overflow`, out, NUM_REQ: sticky; bit i set when a request from i was dropped.
- `comparator_checkpoint`, out, 1: one-cycle start pulse to the checkpoint block.
- `comparator_task_id`, out, KEY_W: granted task ID, held stable from ISSUE through DONE.
- `checkpoint_ack`, in, 1: one-cycle completion from the checkpoint block.
- `busy`, out, 1: high when state != IDLE.
- `err_timeout`, out, 1: sticky; set on any timeout.

## Operation
- Pending store: per requester, one valid bit plus one KEY_W ID register.
  - `req_valid[i]` with pending[i]=0: set pending[i] and capture the ID.
  - `req_valid[i]` with pending[i]=1 and not being cleared this cycle: drop the request and set `req_overflow[i]`.
  - `req_valid[i]` in the same cycle the DONE state clears pending[i]: the new request is accepted and pending[i] stays 1 with the new ID (set wins).
- Round-robin selection:
  - Search starts at `last_grant`+1, modulo NUM_REQ.
  - The first pending requester wins and `last_grant` is updated to it.
  - Reset value of `last_grant` is NUM_REQ-1, so requester 0 has first priority.
- FSM:
  - IDLE: if any pending, latch grant index and ID, go to ISSUE.
  - ISSUE: `comparator_checkpoint`=1; go to WAIT.
  - WAIT: on `checkpoint_ack`, go to DONE (status ok). On timeout, go to DONE (status timeout).
  - DONE: `req_done[grant]`=1; `req_timeout`=status; clear pending[grant]; go to IDLE.
- `checkpoint_ack` outside WAIT is ignored.
- A new pulse is never issued before the previous one is acked or timed out.
- Reset values: all outputs 0, state IDLE, pending all 0, sticky flags 0, `comparator_task_id` 0.
- Reset assertion mid-operation returns to IDLE at once and discards all pending requests. No `req_done` pulse is produced for them.

## Timing
- `req_valid` sampled at edge 0 with scheduler idle:
  - ISSUE from edge 1; `comparator_checkpoint` high in cycle 1–2.
  - WAIT from edge 2.
- Ack sampled high at edge k in WAIT: DONE during cycle k..k+1, `req_done` high that cycle, IDLE at k+1.
- Minimum request-to-done latency: 4 edges when the ack arrives at the first WAIT edge.
- Back-to-back grants: the next ISSUE starts 2 cycles after DONE, via IDLE.
- Timeout counter:
  - Cleared on entry to WAIT and incremented each WAIT cycle without ack.
  - When count == TIMEOUT-1 and no ack, go to DONE with timeout status.
  - An ack in that same cycle takes priority, so status is ok.
- Counter width is clog2(TIMEOUT+1). No wrap is possible.

## Configuration
- Macro: `CHECKPOINT_SCHED_TIMEOUT_EN`.
- Defined: timeout counter, `req_timeout` and `err_timeout` are present as described above.
- Undefined: no counter; WAIT exits only on ack. `req_timeout` and `err_timeout` are tied to 0. Port list is unchanged.

## Test plan
- Single request: requester 2 sends ID 0x5; ack 3 cycles after ISSUE.
  - Exactly one `comparator_checkpoint` pulse with ID 0x5.
  - `req_done`=4'b0100 one cycle after the ack.
  - `req_timeout`=0.
- Simultaneous requests: all 4 requesters pulse in the same cycle; ack each request immediately.
  - Grants in order 0,1,2,3.
  - Then a new request from 3 followed by 0 yields grant order 0 first, because `last_grant`=3.
- Overflow: requester 1 pulses twice while its first request is still pending.
  - `req_overflow`=4'b0010.
  - Only the first ID is issued.
  - A re-request in its DONE cycle is accepted and issued next.
- Timeout with the macro defined and TIMEOUT=8: never ack.
  - `req_done` and `req_timeout` fire 8 cycles after WAIT entry; `err_timeout` stays 1.
  - Repeat with the ack in the 8th cycle: status ok.
- Reset mid-WAIT: assert `reset_n`=0 with 2 requests pending.
  - All outputs 0 immediately.
  - After release there is no `comparator_checkpoint` until a new request arrives.
- Macro undefined: 1000 cycles with no ack leave the FSM in WAIT; `busy`=1 and `err_timeout`=0.
